// File: rtl/game_pkg.sv
// Shared state encoding, default timing parameters and helpers for the round sequencer.
package game_pkg;
  localparam int DEF_TICKS_PER_SEC = 50_000_000;
  localparam int DEF_ROUND_LIMIT   = 99;
  localparam int DEF_MAX_ROUNDS    = 5;

  localparam int TMR_W = 7;
  localparam int CNT_W = 4;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARM      = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_WIN      = 3'd3;
  localparam logic [2:0] ST_LOSE     = 3'd4;
  localparam logic [2:0] ST_WAIT_CLR = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    ARM      = ST_ARM,
    RUN      = ST_RUN,
    WIN      = ST_WIN,
    LOSE     = ST_LOSE,
    WAIT_CLR = ST_WAIT_CLR,
    DONE     = ST_DONE
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sec_timer.sv
// Prescaler plus seconds counter; the seconds value saturates at LIMIT.
module sec_timer #(
  parameter int TICKS = 4,
  parameter int LIMIT = 3,
  parameter int SEC_W = 7
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             enable,
  output logic [SEC_W-1:0] seconds
);
  localparam int PW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [PW-1:0] presc;
  logic          wrap;

  assign wrap = (presc == PW'(TICKS - 1));

  always_ff @(posedge Clock) begin
    if (clear) begin
      presc   <= '0;
      seconds <= '0;
    end else if (enable) begin
      presc <= wrap ? '0 : presc + 1'b1;
      // Saturation matters when TICKS is 1: a wrap can land on the limit cycle itself.
      if (wrap && (seconds != SEC_W'(LIMIT)))
        seconds <= seconds + 1'b1;
    end
  end
endmodule

// File: rtl/round_sequencer.sv
// Game round sequencer: arms the equation checker, times each round, keeps score.
module round_sequencer
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
  parameter int ROUND_LIMIT   = DEF_ROUND_LIMIT,
  parameter int MAX_ROUNDS    = DEF_MAX_ROUNDS
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             correct,
  output logic [TMR_W-1:0] OngoingTimer,
  output logic             startEq1,
  output logic [CNT_W-1:0] Score,
  output logic             RoundActive,
  output logic             Timeout,
  output logic             GameOver
);
  state_t           state;
  logic [CNT_W-1:0] round_cnt;
  logic             tmr_clear;
  logic             tmr_en;

  // Timer control depends only on registered state, never on Start/correct.
  assign tmr_clear = Reset || (state == IDLE) || (state == ARM);
  assign tmr_en    = (state == RUN);

  sec_timer #(
    .TICKS (TICKS_PER_SEC),
    .LIMIT (ROUND_LIMIT),
    .SEC_W (TMR_W)
  ) u_sec_timer (
    .Clock   (Clock),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .seconds (OngoingTimer)
  );

  // Status outputs are registered alongside the next state so they track it exactly.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      round_cnt   <= '0;
      Score       <= '0;
      startEq1    <= 1'b0;
      RoundActive <= 1'b0;
      Timeout     <= 1'b0;
      GameOver    <= 1'b0;
    end else begin
      startEq1    <= 1'b0;
      RoundActive <= 1'b0;
      GameOver    <= 1'b0;
      case (state)
        IDLE: begin
          Score     <= '0;
          round_cnt <= '0;
          if (Start) begin
            state    <= ARM;
            startEq1 <= 1'b1;
          end
        end
        ARM: begin
          Timeout     <= 1'b0;
          state       <= RUN;
          RoundActive <= 1'b1;
        end
        RUN: begin
          if (correct)
            state <= WIN;
          else if (OngoingTimer == TMR_W'(ROUND_LIMIT))
            state <= LOSE;
          else
            RoundActive <= 1'b1;
        end
        WIN: begin
          Score     <= sat_inc(Score);
          round_cnt <= round_cnt + 1'b1;
          state     <= WAIT_CLR;
        end
        LOSE: begin
          Timeout   <= 1'b1;
          round_cnt <= round_cnt + 1'b1;
          state     <= WAIT_CLR;
        end
        WAIT_CLR: begin
          // Wait for the checker to drop correct so one answer cannot win two rounds.
          if (!correct) begin
            if (round_cnt == CNT_W'(MAX_ROUNDS)) begin
              state    <= DONE;
              GameOver <= 1'b1;
            end else begin
              state    <= ARM;
              startEq1 <= 1'b1;
            end
          end
        end
        DONE: begin
          if (Start) begin
            Score     <= '0;
            round_cnt <= '0;
            state     <= ARM;
            startEq1  <= 1'b1;
          end else begin
            GameOver <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/round_sequencer.md
ROUND_SEQUENCER -- requirements
Module: round_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000: Clock cycles per timer second.
REQ-002 SHALL have parameter ROUND_LIMIT, default 99: seconds allowed per round, 1..127.
REQ-003 SHALL have parameter MAX_ROUNDS, default 5: rounds per game, 1..15.
REQ-004 Clock  in  1  system clock; all logic on rising edge.
REQ-005 Reset  in  1  reset, synchronous, active-high.
REQ-006 Start  in  1  player start request, level, sampled every cycle.
REQ-007 correct  in  1  answer-correct flag from the equation checker.
REQ-008 OngoingTimer  out  7  elapsed seconds in current round, fed to the checker.
REQ-009 startEq1  out  1  one-cycle pulse that arms the checker for a new round.
REQ-010 Score  out  4  count of rounds answered correctly.
REQ-011 RoundActive  out  1  high while state is RUN.
REQ-012 Timeout  out  1  high from a timed-out round until the next ARM.
REQ-013 GameOver  out  1  high while state is DONE.

Function
REQ-014 FSM states SHALL be IDLE, ARM, RUN, WIN, LOSE, WAIT_CLR, DONE; all outputs registered.
REQ-015 IDLE: Start=1 -> ARM; otherwise stay; Score, round count, OngoingTimer, prescaler held at 0.
REQ-016 ARM (one cycle): startEq1=1, OngoingTimer<=0, prescaler<=0, Timeout<=0; -> RUN.
REQ-017 startEq1 SHALL be 0 in every state except ARM.
REQ-018 RUN: prescaler counts 0..TICKS_PER_SEC-1 and wraps; on wrap OngoingTimer increments by 1.
REQ-019 RUN: correct=1 -> WIN; else OngoingTimer==ROUND_LIMIT -> LOSE.
REQ-020 correct and limit reached in same cycle SHALL resolve to WIN.
REQ-021 OngoingTimer SHALL never exceed ROUND_LIMIT; frozen outside RUN/ARM.
REQ-022 WIN (one cycle): Score<=Score+1, saturating at 15; round count +1; -> WAIT_CLR.
REQ-023 LOSE (one cycle): Timeout<=1; round count +1; -> WAIT_CLR.
REQ-024 WAIT_CLR: stay while correct=1; when correct=0 -> DONE if round count==MAX_ROUNDS, else ARM.
REQ-025 DONE: GameOver=1, Score held; Start=1 -> clear Score and round count, -> ARM.
REQ-026 Start SHALL be ignored in ARM, RUN, WIN, LOSE, WAIT_CLR.
REQ-027 correct SHALL be ignored in IDLE, ARM, DONE.
REQ-028 Round count 4 bits; comparison uses value after WIN/LOSE increment.

Reset
REQ-029 Reset=1 SHALL force IDLE next edge, overriding any state including mid-RUN.
REQ-030 Reset values: OngoingTimer=0, startEq1=0, Score=0, RoundActive=0, Timeout=0, GameOver=0, prescaler=0, round count=0.

Structure
REQ-031 State encoding localparams and default parameter values SHALL live in shared package game_pkg.
REQ-032 Prescaler plus seconds counter SHALL be sub-module sec_timer (inputs clear, enable; output seconds).
REQ-033 No combinational path from correct or Start to any output.

Verification (TICKS_PER_SEC=4, ROUND_LIMIT=3, MAX_ROUNDS=2)
REQ-034 Reset then Start=1 one cycle -> startEq1 pulse 1 cycle, RoundActive=1 next cycle, OngoingTimer=0.
REQ-035 RUN, no correct -> OngoingTimer 1,2,3 every 4 cycles; at 3 LOSE, Timeout=1, Score=0.
REQ-036 RUN, correct=1 at OngoingTimer=1, held 5 cycles -> Score=1, WAIT_CLR 5 cycles, then startEq1 pulse.
REQ-037 correct=1 in cycle OngoingTimer reaches 3 -> WIN, Score+1, Timeout=0.
REQ-038 Two rounds complete -> GameOver=1, Score stable; Start=1 -> Score=0, startEq1 pulse.
REQ-039 Reset=1 mid-RUN at OngoingTimer=2 -> next cycle all outputs at reset values, state IDLE.
